alu_commit_arbiter: RTL and testbench

//   Shares the single register-file write port and the PC-redirect path among N_UNITS ALUs.

---
 rtl/core_config_pkg.sv | 22 ++
 rtl/rr_picker.sv | 37 +++
 rtl/alu_commit_arbiter.sv | 140 ++++++++++++++
 tb/tb_alu_commit_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/core_config_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : core_config_pkg
//  Brief   : Shared core widths, ALU-bank size and commit-arbiter state type.
//  Revision: 1.0 - initial release
// ============================================================================
package core_config_pkg;

   localparam int XLEN        = 32;
   localparam int REG_ADDR_W  = 5;
   localparam int N_ALU_UNITS = 4;

   localparam logic [N_ALU_UNITS-1:0] C_BRANCH_MASK_DEFAULT = 4'b0010;

   typedef enum logic [1:0] {
      CS_IDLE   = 2'd0,
      CS_COMMIT = 2'd1,
      CS_FLUSH  = 2'd2
   } commit_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// ============================================================================
//  Module  : rr_picker
//  Brief   : Combinational round-robin picker: first set req bit at or after ptr.
//  Revision: 1.0 - initial release
// ============================================================================
module rr_picker #(
   parameter int N  = 4,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [PW-1:0] grant,
   output logic          any
);

   logic [PW:0] w_idx;

   always_comb begin
      grant = '0;
      any   = 1'b0;
      w_idx = '0;
      for (int i = 0; i < N; i++) begin
         // ptr < N and i < N, so one conditional subtract is enough to wrap
         w_idx = {1'b0, ptr} + (PW+1)'(i);
         if (w_idx >= (PW+1)'(N)) begin
            w_idx = w_idx - (PW+1)'(N);
         end
         if (!any && req[w_idx[PW-1:0]]) begin
            grant = w_idx[PW-1:0];
            any   = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/alu_commit_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : alu_commit_arbiter
//  Brief   : Round-robin commit of ALU results to writeback / redirect / exception.
//  Revision: 1.0 - initial release
// ============================================================================
module alu_commit_arbiter
   import core_config_pkg::*;
#(
   parameter int                   N_UNITS     = N_ALU_UNITS,
   parameter logic [N_UNITS-1:0]   BRANCH_MASK = N_UNITS'(C_BRANCH_MASK_DEFAULT),
   parameter int                   PW          = $clog2(N_UNITS)
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [N_UNITS-1:0]                   u_valid,
   input  logic [N_UNITS-1:0][XLEN-1:0]         u_res,
   input  logic [N_UNITS-1:0][REG_ADDR_W-1:0]   u_rd,
   input  logic [N_UNITS-1:0]                   u_error,
   input  logic [N_UNITS-1:0]                   u_req,
   output logic [N_UNITS-1:0]                   u_clear,
   input  logic                                 wb_ready,
   output logic                                 wb_en,
   output logic [REG_ADDR_W-1:0]                wb_rd,
   output logic [XLEN-1:0]                      wb_data,
   output logic                                 redirect_valid,
   output logic [XLEN-1:0]                      redirect_pc,
   output logic                                 exc_valid,
   output logic [PW-1:0]                        exc_unit
);

   commit_state_t          r_state,   w_state_nxt;
   logic [PW-1:0]          r_ptr,     w_ptr_nxt;
   logic [N_UNITS-1:0]     r_mask,    w_mask_nxt;
   logic [N_UNITS-1:0]     r_clear,   w_clear_nxt;
   logic                   r_wb_en,   w_wb_en_nxt;
   logic [REG_ADDR_W-1:0]  r_wb_rd,   w_wb_rd_nxt;
   logic [XLEN-1:0]        r_wb_data, w_wb_data_nxt;
   logic                   r_rd_valid, w_rd_valid_nxt;
   logic [XLEN-1:0]        r_rd_pc,   w_rd_pc_nxt;
   logic                   r_exc_valid, w_exc_valid_nxt;
   logic [PW-1:0]          r_exc_unit,  w_exc_unit_nxt;

   logic [N_UNITS-1:0]     w_elig;
   logic [PW-1:0]          w_g;
   logic                   w_any;
   logic                   w_grant;

   assign w_elig  = u_valid & ~r_mask;
   assign w_grant = (r_state != CS_FLUSH) && w_any && wb_ready;

   rr_picker #(
      .N  (N_UNITS),
      .PW (PW)
   ) u_picker (
      .req   (w_elig),
      .ptr   (r_ptr),
      .grant (w_g),
      .any   (w_any)
   );

   always_comb begin
      w_state_nxt     = CS_IDLE;
      w_ptr_nxt       = r_ptr;
      w_mask_nxt      = '0;
      w_clear_nxt     = '0;
      w_wb_en_nxt     = 1'b0;
      w_wb_rd_nxt     = r_wb_rd;
      w_wb_data_nxt   = r_wb_data;
      w_rd_valid_nxt  = 1'b0;
      w_rd_pc_nxt     = r_rd_pc;
      w_exc_valid_nxt = 1'b0;
      w_exc_unit_nxt  = r_exc_unit;

      if (r_state == CS_FLUSH) begin
         // Retire everything in flight; the all-ones mask covers valid's one-cycle lag
         w_clear_nxt = '1;
         w_mask_nxt  = '1;
      end else if (w_grant) begin
         w_clear_nxt[w_g] = 1'b1;
         w_mask_nxt[w_g]  = 1'b1;
         w_ptr_nxt        = (w_g == PW'(N_UNITS-1)) ? '0 : w_g + PW'(1);
         if (u_error[w_g]) begin
            w_exc_valid_nxt = 1'b1;
            w_exc_unit_nxt  = w_g;
            w_state_nxt     = CS_FLUSH;
         end else if (BRANCH_MASK[w_g] && u_req[w_g]) begin
            w_rd_valid_nxt = 1'b1;
            w_rd_pc_nxt    = u_res[w_g];
            w_state_nxt    = CS_FLUSH;
         end else begin
            w_state_nxt = CS_COMMIT;
            if (u_rd[w_g] != '0) begin
               w_wb_en_nxt   = 1'b1;
               w_wb_rd_nxt   = u_rd[w_g];
               w_wb_data_nxt = u_res[w_g];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= CS_IDLE;
         r_ptr       <= '0;
         r_mask      <= '0;
         r_clear     <= '0;
         r_wb_en     <= 1'b0;
         r_wb_rd     <= '0;
         r_wb_data   <= '0;
         r_rd_valid  <= 1'b0;
         r_rd_pc     <= '0;
         r_exc_valid <= 1'b0;
         r_exc_unit  <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_ptr       <= w_ptr_nxt;
         r_mask      <= w_mask_nxt;
         r_clear     <= w_clear_nxt;
         r_wb_en     <= w_wb_en_nxt;
         r_wb_rd     <= w_wb_rd_nxt;
         r_wb_data   <= w_wb_data_nxt;
         r_rd_valid  <= w_rd_valid_nxt;
         r_rd_pc     <= w_rd_pc_nxt;
         r_exc_valid <= w_exc_valid_nxt;
         r_exc_unit  <= w_exc_unit_nxt;
      end
   end

   assign u_clear        = r_clear;
   assign wb_en          = r_wb_en;
   assign wb_rd          = r_wb_rd;
   assign wb_data        = r_wb_data;
   assign redirect_valid = r_rd_valid;
   assign redirect_pc    = r_rd_pc;
   assign exc_valid      = r_exc_valid;
   assign exc_unit       = r_exc_unit;

endmodule
`default_nettype wire

// File: tb/tb_alu_commit_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_alu_commit_arbiter
//  Brief   : Directed self-checking bench for alu_commit_arbiter.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_alu_commit_arbiter;
   import core_config_pkg::*;

   logic                              clk;
   logic                              rst_n;
   logic [3:0]                        u_valid;
   logic [3:0][XLEN-1:0]              u_res;
   logic [3:0][REG_ADDR_W-1:0]        u_rd;
   logic [3:0]                        u_error;
   logic [3:0]                        u_req;
   logic [3:0]                        u_clear;
   logic                              wb_ready;
   logic                              wb_en;
   logic [REG_ADDR_W-1:0]             wb_rd;
   logic [XLEN-1:0]                   wb_data;
   logic                              redirect_valid;
   logic [XLEN-1:0]                   redirect_pc;
   logic                              exc_valid;
   logic [1:0]                        exc_unit;

   int n_checks = 0;
   int n_fail   = 0;
   int clr_cnt[4];

   alu_commit_arbiter dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .u_valid        (u_valid),
      .u_res          (u_res),
      .u_rd           (u_rd),
      .u_error        (u_error),
      .u_req          (u_req),
      .u_clear        (u_clear),
      .wb_ready       (wb_ready),
      .wb_en          (wb_en),
      .wb_rd          (wb_rd),
      .wb_data        (wb_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .exc_valid      (exc_valid),
      .exc_unit       (exc_unit)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".clear"}, 64'(u_clear), 64'h0);
      chk({tag, ".wb_en"}, 64'(wb_en), 64'h0);
      chk({tag, ".redir"}, 64'(redirect_valid), 64'h0);
      chk({tag, ".exc"},   64'(exc_valid), 64'h0);
   endtask

   initial begin
      rst_n    = 1'b0;
      u_valid  = '0;
      u_error  = '0;
      u_req    = '0;
      wb_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         u_res[i]   = 32'h100 + 32'(i);
         u_rd[i]    = 5'd5;
         clr_cnt[i] = 0;
      end
      tick();
      tick();
      chk_idle("reset");
      chk("reset.wb_data", 64'(wb_data), 64'h0);
      rst_n = 1'b1;

      // Round-robin: all four valid, grants 0,1,2,3 then 0 again
      u_valid = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("rr.clear", 64'(u_clear), 64'(4'b0001 << k));
         chk("rr.wb_en", 64'(wb_en), 64'h1);
         chk("rr.wb_rd", 64'(wb_rd), 64'h5);
         chk("rr.wb_data", 64'(wb_data), 64'h100 + 64'(k));
         for (int b = 0; b < 4; b++) clr_cnt[b] += int'(u_clear[b]);
      end
      for (int b = 0; b < 4; b++) chk("rr.fair", 64'(clr_cnt[b]), 64'h1);
      tick();
      chk("rr.wrap", 64'(u_clear), 64'h1);
      u_valid = '0;
      tick();
      chk_idle("rr.drain");

      // Backpressure on unit 2 (ptr=1)
      u_valid  = 4'b0100;
      wb_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk_idle("bp.stall");
      end
      wb_ready = 1'b1;
      tick();
      chk("bp.clear", 64'(u_clear), 64'h4);
      chk("bp.wb_en", 64'(wb_en), 64'h1);
      chk("bp.wb_data", 64'(wb_data), 64'h102);
      u_valid = '0;
      tick();
      chk_idle("bp.after");
      chk("bp.hold_rd", 64'(wb_rd), 64'h5);
      chk("bp.hold_data", 64'(wb_data), 64'h102);

      // Error on unit 3 (ptr=3) while unit 0 also valid
      u_valid = 4'b1001;
      u_error = 4'b1000;
      tick();
      chk("err.exc", 64'(exc_valid), 64'h1);
      chk("err.unit", 64'(exc_unit), 64'h3);
      chk("err.wb_en", 64'(wb_en), 64'h0);
      chk("err.clear", 64'(u_clear), 64'h8);
      u_valid = 4'b0001;
      u_error = '0;
      tick();
      chk("err.flush", 64'(u_clear), 64'hF);
      chk("err.flush_exc", 64'(exc_valid), 64'h0);
      chk("err.flush_wb", 64'(wb_en), 64'h0);
      chk("err.hold_unit", 64'(exc_unit), 64'h3);
      u_valid = '0;
      tick();
      chk_idle("err.idle");
      chk("err.unwritten", 64'(wb_data), 64'h102);

      // Branch on unit 1 (ptr=0)
      u_valid  = 4'b0010;
      u_req    = 4'b0010;
      u_res[1] = 32'h0000_0400;
      tick();
      chk("br.valid", 64'(redirect_valid), 64'h1);
      chk("br.pc", 64'(redirect_pc), 64'h400);
      chk("br.wb_en", 64'(wb_en), 64'h0);
      chk("br.clear", 64'(u_clear), 64'h2);
      u_valid = '0;
      u_req   = '0;
      tick();
      chk("br.flush", 64'(u_clear), 64'hF);
      chk("br.flush_redir", 64'(redirect_valid), 64'h0);
      tick();
      chk_idle("br.idle");
      chk("br.hold_pc", 64'(redirect_pc), 64'h400);

      // rd=0 on unit 0 (ptr=2): retire without write, masked next cycle
      u_valid = 4'b0001;
      u_rd[0] = 5'd0;
      tick();
      chk("rd0.clear", 64'(u_clear), 64'h1);
      chk("rd0.wb_en", 64'(wb_en), 64'h0);
      tick();
      chk_idle("rd0.masked");
      tick();
      chk("rd0.regrant", 64'(u_clear), 64'h1);
      u_valid = '0;
      u_rd[0] = 5'd5;
      tick();
      chk_idle("rd0.drain");

      // Reset mid-grant (ptr=1): grant unit 1, then async reset
      u_valid = 4'b1111;
      tick();
      chk("rst.pre_clear", 64'(u_clear), 64'h2);
      chk("rst.pre_wb", 64'(wb_en), 64'h1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_idle("rst.async");
      chk("rst.wb_rd", 64'(wb_rd), 64'h0);
      chk("rst.wb_data", 64'(wb_data), 64'h0);
      chk("rst.pc", 64'(redirect_pc), 64'h0);
      chk("rst.exc_unit", 64'(exc_unit), 64'h0);
      tick();
      chk_idle("rst.held");
      rst_n = 1'b1;
      tick();
      chk("rst.first", 64'(u_clear), 64'h1);
      chk("rst.first_data", 64'(wb_data), 64'h100);
      u_valid = '0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
